fp_add_issuer: RTL and testbench

Front-end and sequencer for the FP32 adder. Accepts two packed IEEE-754 single-precision operands and an add/sub opcode from the requester, unpacks and classifies them, and computes the larger-operand flag and the exponent shift. It then drives the adder's decomposed-operand interface with a one-cycle `data_ready` strobe, captures the adder's result, and returns it to the requester over a valid/ready handshake. It resolves zero-operand and exact-cancellation cases locally without using the adder, and recovers from a non-responding adder with a watchdog.

---
 rtl/fpu_pkg.sv | 29 ++
 rtl/fp32_classify.sv | 26 ++
 rtl/fp_add_issuer.sv | 178 +++++++++++++++++
 tb/tb_fp_add_issuer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FP32 field types, constants and issuer state encoding
package fpu_pkg;

  localparam int FP32_W = 32;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int RM_W   = 7;

  localparam logic [EXP_W-1:0]  FP32_EXP_MAX = 8'hFF;
  localparam logic [FP32_W-1:0] FP32_QNAN    = 32'h7FFFFFFF;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
    logic              is_zero;
    logic              is_inf;
    logic              is_nan;
  } fp32_fields_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLASSIFY,
    ST_ISSUE,
    ST_WAIT,
    ST_RESPOND
  } issuer_state_t;

endpackage

// File: rtl/fp32_classify.sv
// rtl/fp32_classify.sv - combinational FP32 unpack and class detection
module fp32_classify
  import fpu_pkg::*;
(
  input  logic [FP32_W-1:0] value,
  output fp32_fields_t      fields
);

  logic [EXP_W-1:0]  raw_exp;
  logic [FRAC_W-1:0] raw_frac;

  assign raw_exp  = value[30:23];
  assign raw_frac = value[22:0];

  // Subnormals become signed zero, so the fraction is dropped whenever exp is 0.
  always_comb begin
    fields         = '0;
    fields.sign    = value[31];
    fields.exp     = raw_exp;
    fields.is_zero = (raw_exp == '0);
    fields.is_inf  = (raw_exp == FP32_EXP_MAX) && (raw_frac == '0);
    fields.is_nan  = (raw_exp == FP32_EXP_MAX) && (raw_frac != '0);
    fields.frac    = fields.is_zero ? '0 : raw_frac;
  end

endmodule

// File: rtl/fp_add_issuer.sv
// rtl/fp_add_issuer.sv - FP32 adder front-end: classify, bypass trivial cases, issue, watchdog
module fp_add_issuer
  import fpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int SHIFT_CLAMP    = 26
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [FP32_W-1:0] x_i,
  input  logic [FP32_W-1:0] y_i,
  input  logic              op_sub_i,
  input  logic [RM_W-1:0]   rounding_mode_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [FP32_W-1:0] z_o,
  output logic              except_invalid_operation_o,
  output logic              except_overflow_o,
  output logic              timeout_o,
  output logic              add_data_ready_o,
  output logic [RM_W-1:0]   add_rounding_mode_o,
  output logic              x_sign_o,
  output logic              y_sign_o,
  output logic [EXP_W-1:0]  x_exp_o,
  output logic [EXP_W-1:0]  y_exp_o,
  output logic [FRAC_W-1:0] x_frac_o,
  output logic [FRAC_W-1:0] y_frac_o,
  output logic              x_greater_o,
  output logic [7:0]        exp_shift_o,
  output logic              x_infinity_o,
  output logic              y_infinity_o,
  output logic              x_nan_o,
  output logic              y_nan_o,
  input  logic              add_data_valid_i,
  input  logic [FP32_W-1:0] add_z_i,
  input  logic              add_invalid_i,
  input  logic              add_overflow_i
);

  issuer_state_t     state, state_next;
  logic [FP32_W-1:0] op_x, op_y;
  logic [RM_W-1:0]   op_rm;
  logic [7:0]        wd_cnt;
  fp32_fields_t      xf, yf;

  logic              accept, wd_expire;
  logic              x_ge, special, bypass;
  logic [EXP_W-1:0]  exp_diff;
  logic [7:0]        shift_sat;
  logic [FP32_W-1:0] byp_z;

  assign accept    = req_valid_i && req_ready_o;
  assign wd_expire = (wd_cnt == 8'(TIMEOUT_CYCLES - 1));

  // op_y is latched with the effective sign already applied.
  fp32_classify u_class_x (.value(op_x), .fields(xf));
  fp32_classify u_class_y (.value(op_y), .fields(yf));

  always_comb begin
    x_ge      = (xf.exp > yf.exp) || ((xf.exp == yf.exp) && (xf.frac >= yf.frac));
    exp_diff  = (xf.exp >= yf.exp) ? (xf.exp - yf.exp) : (yf.exp - xf.exp);
    shift_sat = (exp_diff > 8'(SHIFT_CLAMP)) ? 8'(SHIFT_CLAMP) : exp_diff;
    special   = xf.is_inf || xf.is_nan || yf.is_inf || yf.is_nan;
    bypass    = 1'b0;
    byp_z     = '0;
    if (!special) begin
      if (xf.is_zero && yf.is_zero) begin
        bypass = 1'b1;
        byp_z  = {xf.sign & yf.sign, 31'd0};
      end else if (xf.is_zero) begin
        bypass = 1'b1;
        byp_z  = {yf.sign, yf.exp, yf.frac};
      end else if (yf.is_zero) begin
        bypass = 1'b1;
        byp_z  = {xf.sign, xf.exp, xf.frac};
      end else if ((xf.exp == yf.exp) && (xf.frac == yf.frac) && (xf.sign != yf.sign)) begin
        bypass = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (accept) state_next = ST_CLASSIFY;
      ST_CLASSIFY: state_next = bypass ? ST_RESPOND : ST_ISSUE;
      ST_ISSUE:    state_next = ST_WAIT;
      ST_WAIT:     if (add_data_valid_i || wd_expire) state_next = ST_RESPOND;
      ST_RESPOND:  if (res_valid_o && res_ready_i) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= ST_IDLE;
      req_ready_o      <= 1'b0;
      add_data_ready_o <= 1'b0;
      res_valid_o      <= 1'b0;
      wd_cnt           <= '0;
      op_x             <= '0;
      op_y             <= '0;
      op_rm            <= '0;
    end else begin
      state            <= state_next;
      req_ready_o      <= (state_next == ST_IDLE);
      add_data_ready_o <= (state == ST_ISSUE);
      if (accept) begin
        op_x  <= x_i;
        op_y  <= {y_i[31] ^ op_sub_i, y_i[30:0]};
        op_rm <= rounding_mode_i;
      end
      if (state == ST_ISSUE) wd_cnt <= '0;
      else if (state == ST_WAIT && !add_data_valid_i && !wd_expire) wd_cnt <= wd_cnt + 8'd1;
      // Valid trails state by one cycle, but drops on the handshake edge itself.
      if (res_valid_o && res_ready_i) res_valid_o <= 1'b0;
      else if (state == ST_RESPOND)   res_valid_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      add_rounding_mode_o        <= '0;
      x_sign_o                   <= 1'b0;
      y_sign_o                   <= 1'b0;
      x_exp_o                    <= '0;
      y_exp_o                    <= '0;
      x_frac_o                   <= '0;
      y_frac_o                   <= '0;
      x_greater_o                <= 1'b0;
      exp_shift_o                <= '0;
      x_infinity_o               <= 1'b0;
      y_infinity_o               <= 1'b0;
      x_nan_o                    <= 1'b0;
      y_nan_o                    <= 1'b0;
      z_o                        <= '0;
      except_invalid_operation_o <= 1'b0;
      except_overflow_o          <= 1'b0;
      timeout_o                  <= 1'b0;
    end else if (state == ST_CLASSIFY) begin
      add_rounding_mode_o <= op_rm;
      x_sign_o            <= xf.sign;
      y_sign_o            <= yf.sign;
      x_exp_o             <= xf.exp;
      y_exp_o             <= yf.exp;
      x_frac_o            <= xf.frac;
      y_frac_o            <= yf.frac;
      x_greater_o         <= x_ge;
      exp_shift_o         <= shift_sat;
      x_infinity_o        <= xf.is_inf;
      y_infinity_o        <= yf.is_inf;
      x_nan_o             <= xf.is_nan;
      y_nan_o             <= yf.is_nan;
      if (bypass) begin
        z_o                        <= byp_z;
        except_invalid_operation_o <= 1'b0;
        except_overflow_o          <= 1'b0;
        timeout_o                  <= 1'b0;
      end
    end else if (state == ST_WAIT) begin
      // A result strobe on the expiry cycle still wins over the watchdog.
      if (add_data_valid_i) begin
        z_o                        <= add_z_i;
        except_invalid_operation_o <= add_invalid_i;
        except_overflow_o          <= add_overflow_i;
        timeout_o                  <= 1'b0;
      end else if (wd_expire) begin
        z_o                        <= FP32_QNAN;
        except_invalid_operation_o <= 1'b1;
        except_overflow_o          <= 1'b0;
        timeout_o                  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fp_add_issuer.sv
// tb/tb_fp_add_issuer.sv - vector table plus scoreboard bench for fp_add_issuer
module tb_fp_add_issuer;

  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [31:0] x = '0, y = '0;
  logic        op_sub = 1'b0;
  logic [6:0]  rm = '0;
  logic        res_valid, res_ready = 1'b0;
  logic [31:0] z;
  logic        inv, ovf, tmo;
  logic        add_rdy;
  logic [6:0]  add_rm;
  logic        xs, ys, xg, xinf, yinf, xnan, ynan;
  logic [7:0]  xe, ye, shift;
  logic [22:0] xfr, yfr;
  logic        add_valid = 1'b0;
  logic [31:0] add_z = '0;
  logic        add_inv = 1'b0, add_ovf = 1'b0;
  logic        any_out;

  fp_add_issuer dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .x_i(x), .y_i(y), .op_sub_i(op_sub), .rounding_mode_i(rm),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .z_o(z),
    .except_invalid_operation_o(inv), .except_overflow_o(ovf), .timeout_o(tmo),
    .add_data_ready_o(add_rdy), .add_rounding_mode_o(add_rm),
    .x_sign_o(xs), .y_sign_o(ys), .x_exp_o(xe), .y_exp_o(ye),
    .x_frac_o(xfr), .y_frac_o(yfr), .x_greater_o(xg), .exp_shift_o(shift),
    .x_infinity_o(xinf), .y_infinity_o(yinf), .x_nan_o(xnan), .y_nan_o(ynan),
    .add_data_valid_i(add_valid), .add_z_i(add_z),
    .add_invalid_i(add_inv), .add_overflow_i(add_ovf)
  );

  assign any_out = |{req_ready, res_valid, z, inv, ovf, tmo, add_rdy, add_rm, xs, ys, xe, ye,
                     xfr, yfr, xg, shift, xinf, yinf, xnan, ynan};

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x, y;
    logic        sub;
    bit          issue;
    int          delay;
    int          rdy_delay;
    logic [31:0] az;
    logic        ainv, aovf;
    logic [31:0] ez;
    logic        einv, eovf, eto;
    logic [7:0]  eshift;
    logic        exg;
  } vec_t;

  typedef struct {
    logic [31:0] z;
    logic        inv, ovf, to;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] vx, vy, input logic sub, input bit issue,
                              input int delay, rdy_delay, input logic [31:0] az,
                              input logic ainv, aovf, input logic [31:0] ez,
                              input logic einv, eovf, eto, input logic [7:0] eshift,
                              input logic exg);
    vec_t v;
    v.x = vx; v.y = vy; v.sub = sub; v.issue = issue; v.delay = delay;
    v.rdy_delay = rdy_delay; v.az = az; v.ainv = ainv; v.aovf = aovf;
    v.ez = ez; v.einv = einv; v.eovf = eovf; v.eto = eto; v.eshift = eshift; v.exg = exg;
    return v;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int   cyc = 0, strobes = 0, strobe_cyc = -1, fire_at = -1, res_cyc = -1;
    int   hold = 0, busy_rdy = 0, w = 0, exp_lat;
    bit   done = 0;
    exp_t e;
    logic [6:0] vrm;
    string p;
    p = $sformatf("v%0d_", idx);
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    if (!req_ready) begin
      chk({p, "req_ready_wait"}, 32'(req_ready), 32'd1);
      return;
    end
    vrm = 7'($urandom_range(0, 127));
    x = v.x; y = v.y; op_sub = v.sub; rm = vrm; req_valid = 1'b1;
    e.z = v.ez; e.inv = v.einv; e.ovf = v.eovf; e.to = v.eto;
    sb_q.push_back(e);
    exp_lat = v.eto ? 19 : (v.issue ? 3 + v.delay + 2 : 3);
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) req_valid = 1'b0;
      if (res_ready) begin
        res_ready = 1'b0;
        done = 1;
        chk({p, "ready_after"}, 32'(req_ready), 32'd1);
      end else begin
        if (add_rdy) begin
          strobes++;
          if (strobes == 1) begin
            strobe_cyc = cyc;
            if (v.delay >= 0) fire_at = cyc + v.delay;
            chk({p, "x_exp"}, 32'(xe), 32'(v.x[30:23]));
            chk({p, "y_exp"}, 32'(ye), 32'(v.y[30:23]));
            chk({p, "x_frac"}, 32'(xfr), 32'(v.x[22:0]));
            chk({p, "y_sign"}, 32'(ys), 32'(v.y[31] ^ v.sub));
            chk({p, "shift"}, 32'(shift), 32'(v.eshift));
            chk({p, "x_greater"}, 32'(xg), 32'(v.exg));
            chk({p, "x_inf"}, 32'(xinf), 32'(v.x[30:23] == 8'hFF && v.x[22:0] == 0));
            chk({p, "x_nan"}, 32'(xnan), 32'(v.x[30:23] == 8'hFF && v.x[22:0] != 0));
            chk({p, "rm"}, 32'(add_rm), 32'(vrm));
          end
        end
        if (req_ready) busy_rdy++;
        if (res_valid) begin
          if (res_cyc < 0) begin
            res_cyc = cyc;
            hold = v.rdy_delay;
            chk({p, "latency"}, 32'(res_cyc), 32'(exp_lat));
            if (sb_q.size() == 0) begin
              chk({p, "sb_empty"}, 32'(sb_q.size()), 32'd1);
            end else begin
              e = sb_q.pop_front();
              chk({p, "z"}, z, e.z);
              chk({p, "flags"}, {29'd0, inv, ovf, tmo}, {29'd0, e.inv, e.ovf, e.to});
            end
          end
          if (hold == 0) begin
            res_ready = 1'b1;
            chk({p, "z_hold"}, z, v.ez);
          end else begin
            hold--;
          end
        end
      end
      add_valid = (cyc == fire_at);
      add_z = v.az; add_inv = v.ainv; add_ovf = v.aovf;
    end
    add_valid = 1'b0;
    res_ready = 1'b0;
    if (!done) chk({p, "result_timeout"}, 32'(res_cyc), 32'(exp_lat));
    chk({p, "strobes"}, 32'(strobes), 32'(v.issue));
    if (v.issue) chk({p, "strobe_cycle"}, 32'(strobe_cyc), 32'd3);
    chk({p, "busy_ready"}, 32'(busy_rdy), 32'd0);
  endtask

  initial begin
    vecs.push_back(mk(32'h3F800000, 32'h40000000, 0, 1, 4, 0, 32'h40400000, 0, 0, 32'h40400000, 0, 0, 0, 8'd1, 0));
    vecs.push_back(mk(32'h40490FDB, 32'h40490FDB, 1, 0, -1, 0, 32'h0, 0, 0, 32'h00000000, 0, 0, 0, 8'd0, 0));
    vecs.push_back(mk(32'h00000000, 32'h41200000, 1, 0, -1, 1, 32'h0, 0, 0, 32'hC1200000, 0, 0, 0, 8'd0, 0));
    vecs.push_back(mk(32'h3F800000, 32'h28000000, 0, 1, 2, 0, 32'h3F800000, 0, 0, 32'h3F800000, 0, 0, 0, 8'd26, 1));
    vecs.push_back(mk(32'h3F800000, 32'h33800000, 0, 1, 3, 1, 32'h3F800000, 0, 0, 32'h3F800000, 0, 0, 0, 8'd24, 1));
    vecs.push_back(mk(32'h3F800000, 32'h32800000, 0, 1, 1, 0, 32'h3F800000, 0, 0, 32'h3F800000, 0, 0, 0, 8'd26, 1));
    vecs.push_back(mk(32'h3F800000, 32'h32000000, 0, 1, 1, 0, 32'h3F800001, 0, 0, 32'h3F800001, 0, 0, 0, 8'd26, 1));
    vecs.push_back(mk(32'h7F800000, 32'h3F800000, 0, 1, 1, 0, 32'h7F800000, 0, 1, 32'h7F800000, 0, 1, 0, 8'd26, 1));
    vecs.push_back(mk(32'h80000000, 32'h00000000, 1, 0, -1, 0, 32'h0, 0, 0, 32'h80000000, 0, 0, 0, 8'd0, 0));
    vecs.push_back(mk(32'h80000000, 32'h80000000, 1, 0, -1, 0, 32'h0, 0, 0, 32'h00000000, 0, 0, 0, 8'd0, 0));
    vecs.push_back(mk(32'h00000001, 32'h3F800000, 0, 0, -1, 0, 32'h0, 0, 0, 32'h3F800000, 0, 0, 0, 8'd0, 0));
    vecs.push_back(mk(32'hBF800000, 32'h00400000, 1, 0, -1, 0, 32'h0, 0, 0, 32'hBF800000, 0, 0, 0, 8'd0, 0));
    vecs.push_back(mk(32'h3F800000, 32'h40000000, 0, 1, 17, 3, 32'hDEADBEEF, 0, 1, 32'h7FFFFFFF, 1, 0, 1, 8'd1, 0));
    vecs.push_back(mk(32'h3F800000, 32'h40000000, 0, 1, 14, 0, 32'h40400000, 0, 1, 32'h40400000, 0, 1, 0, 8'd1, 0));
    vecs.push_back(mk(32'h7FC00000, 32'h3F800000, 0, 1, 0, 0, 32'h7FC00000, 1, 0, 32'h7FC00000, 1, 0, 0, 8'd26, 1));
    vecs.push_back(mk(32'h7F800000, 32'h7F800000, 1, 1, 2, 0, 32'h7FC00000, 1, 0, 32'h7FC00000, 1, 0, 0, 8'd0, 1));
    vecs.push_back(mk(32'h40490FDB, 32'h40490FDB, 0, 1, 5, 0, 32'h40C90FDB, 0, 0, 32'h40C90FDB, 0, 0, 0, 8'd0, 1));
    vecs.push_back(mk(32'hC0000000, 32'h3F800000, 1, 1, 1, 0, 32'hC0400000, 0, 0, 32'hC0400000, 0, 0, 0, 8'd1, 1));

    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'(any_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready_first_edge", 32'(req_ready), 32'd1);

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // Reset while the adder request is outstanding.
    x = 32'h3F800000; y = 32'h40000000; op_sub = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("rstwait_pre_x_exp", 32'(xe), 32'h7F);
    #2 rst = 1'b1;
    #1 chk("rstwait_outputs", 32'(any_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstwait_ready_first_edge", 32'(req_ready), 32'd1);
    run_vec(100, vecs[0]);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit actual=expired required=finished");
    $fatal(1);
  end

endmodule
